rom_dl_sequencer: RTL and testbench
===================================

// Module: rom_dl_sequencer
// PURPOSE
// Sequences the HPS ROM download stream into the core's ROM resources.
// Buffers ioctl byte writes, decodes the address region, and routes each byte:
//  - SDRAM port1: every byte, mirror of the full image.
// Also routes to the sprite SDRAM port2, the sound-ROM BRAM and the PROM loader.
// Replaces ad-hoc toggle logic; throttles HPS via dl_wait and flags rom_loaded.
// PARAMETERS
// FIFO_DEPTH  4         entries in the write buffer; must be a power of 2, >=2
// SND_LO      'h20000   first sound-ROM byte (BRAM copy)
// SP_BASE     'h30000   first byte mirrored to port2; port2 addr = addr-SP_BASE
// PROM_BASE   'hA0000   first PROM byte; prom_addr = addr-PROM_BASE
// TIMEOUT     1023      max clk_sys cycles waiting for an SDRAM ack
// PORTS
// clk_sys      in   1   system clock
// reset_n      in   1   asynchronous active-low reset
// dl_active    in   1   ROM download in progress (ioctl_download & index==0)
// dl_wr        in   1   byte strobe, level; rising edge = one byte
// dl_addr      in   25  byte address
// dl_data      in   8   byte data
// dl_wait      out  1   throttle to HPS (ioctl_wait)
// p1_req       out  1   port1 toggle request
// p1_ack       in   1   port1 toggle ack (equal to req = done)
// p1_a         out  23  port1 word address (addr[23:1])
// p1_ds        out  2   byte select {addr[0], ~addr[0]}
// p1_d         out  16  {data,data}
// p2_req/p2_ack/p2_a/p2_ds/p2_d  same as port1, for sprite port
// snd_we       out  1   1-cycle sound BRAM write
// snd_addr     out  16  sound BRAM address (addr[15:0])
// snd_data     out  8   sound BRAM data
// prom_we      out  1   1-cycle PROM write
// prom_addr    out  12  PROM offset
// prom_data    out  8   PROM data
// rom_loaded   out  1   set when download finished and drained
// err_ovf      out  1   sticky FIFO overflow (byte dropped)
// err_tmo      out  1   sticky ack timeout
// BEHAVIOUR
// - Reset: all outputs 0; req toggles 0; FIFO empty; FSM IDLE.
// - Push: dl_wr rising edge while dl_active -> {addr,data} enters FIFO.
//   Entry is visible next cycle.
//   Push when full: byte dropped, err_ovf<=1.
//   Simultaneous push+pop allowed; count is unchanged.
// - dl_wait = (count >= FIFO_DEPTH-1) | (state != IDLE & count != 0).
// - FSM IDLE->ISSUE: FIFO non-empty; pop head into holding regs.
// - FSM ISSUE (1 cycle):
//   - Toggle p1_req.
//   - Toggle p2_req if addr>=SP_BASE & addr<PROM_BASE.
//   - Pulse snd_we if SND_LO<=addr<SP_BASE.
//   - Pulse prom_we if addr>=PROM_BASE.
//   - Addr/data outputs are held stable until the next ISSUE.
// - FSM WAIT: exit to IDLE once p1_ack==p1_req and p2_ack==p2_req.
//   Timeout counter reaches TIMEOUT -> err_tmo<=1, IDLE; the byte is lost.
// - Latency: strobe edge at N -> req toggle registered at N+2, FIFO empty & IDLE.
// - DRAIN: dl_active falls -> finish every queued entry.
//   FIFO empty & IDLE -> rom_loaded<=1.
// - dl_active rising edge clears rom_loaded, err_ovf and err_tmo.
//   Bytes still in the FIFO are kept.
// - Strobes with dl_active=0 are ignored.
// - Reset mid-operation aborts everything; the SDRAM side is reset in the same domain.
// STRUCTURE
// - Package rom_dl_pkg holds:
//   - state_t {IDLE,ISSUE,WAIT}
//   - region_t {R_CPU,R_SND,R_SPR,R_PROM}
//   - region base localparams
//   - decode_region() function
// - Sub-module dl_fifo: synchronous FIFO with count, full and empty flags.
// TESTING
// - Byte at 'h00010=8'hA5: p1_req toggles, p1_a='h8, p1_ds=2'b01.
//   No p2/snd/prom activity.
// - Byte at 'h20003=8'h3C: p1 toggles and snd_we pulses once with snd_addr='h0003.
// - Byte at 'h30001=8'h77: both reqs toggle, p2_a=0, p2_ds=2'b10.
//   WAIT is held until both acks match.
// - Byte at 'hA0005: prom_we pulses once with prom_addr=5; p1 toggles.
//   Nothing toggles on p2.
// - Acks held for 20 cycles while 6 strobes arrive:
//   dl_wait rises at count 3, no drops, err_ovf=0, all 6 issued in order.
// - p1_ack stuck: err_tmo=1 after 1023 cycles and FSM returns to IDLE.
//   dl_active fall then sets rom_loaded after drain.

Source files
------------

// File: rtl/rom_dl_sequencer_pkg.sv
// Shared types and region decode for the ROM download sequencer.
package rom_dl_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;

  typedef enum logic [1:0] {R_CPU, R_SND, R_SPR, R_PROM} region_t;

  localparam logic [24:0] SND_LO_DEF    = 25'h20000;
  localparam logic [24:0] SP_BASE_DEF   = 25'h30000;
  localparam logic [24:0] PROM_BASE_DEF = 25'hA0000;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  // Regions are contiguous and ascending, so test from the top down.
  function automatic region_t decode_region(input logic [24:0] addr,
                                            input logic [24:0] snd_lo,
                                            input logic [24:0] sp_base,
                                            input logic [24:0] prom_base);
    if (addr >= prom_base) return R_PROM;
    if (addr >= sp_base)   return R_SPR;
    if (addr >= snd_lo)    return R_SND;
    return R_CPU;
  endfunction

endpackage

// File: rtl/rom_dl_sequencer_if.sv
// HPS download stream, SDRAM toggle ports, BRAM/PROM writes and status.
interface rom_dl_sequencer_if;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        p1_req;
  logic        p1_ack;
  logic [22:0] p1_a;
  logic [1:0]  p1_ds;
  logic [15:0] p1_d;
  logic        p2_req;
  logic        p2_ack;
  logic [22:0] p2_a;
  logic [1:0]  p2_ds;
  logic [15:0] p2_d;
  logic        snd_we;
  logic [15:0] snd_addr;
  logic [7:0]  snd_data;
  logic        prom_we;
  logic [11:0] prom_addr;
  logic [7:0]  prom_data;
  logic        rom_loaded;
  logic        err_ovf;
  logic        err_tmo;

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data, p1_ack, p2_ack,
    output dl_wait, p1_req, p1_a, p1_ds, p1_d, p2_req, p2_a, p2_ds, p2_d,
           snd_we, snd_addr, snd_data, prom_we, prom_addr, prom_data,
           rom_loaded, err_ovf, err_tmo
  );

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data, p1_ack, p2_ack,
    input  dl_wait, p1_req, p1_a, p1_ds, p1_d, p2_req, p2_a, p2_ds, p2_d,
           snd_we, snd_addr, snd_data, prom_we, prom_addr, prom_data,
           rom_loaded, err_ovf, err_tmo
  );
endinterface

// File: rtl/rom_dl_sequencer_fifo.sv
// Byte write buffer: power-of-2 circular FIFO with occupancy count.
module dl_fifo
  import rom_dl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  dl_entry_t     wdata,
  output dl_entry_t     rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  dl_entry_t     mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_wr, do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_wr = push & (~full | do_rd);
  assign rdata = mem[rp];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Buffers HPS ROM download bytes and routes each one to SDRAM ports, sound BRAM and PROM.
module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] SND_LO     = SND_LO_DEF,
  parameter logic [24:0] SP_BASE    = SP_BASE_DEF,
  parameter logic [24:0] PROM_BASE  = PROM_BASE_DEF,
  parameter int          TIMEOUT    = 1023
) (
  input logic                clk_sys,
  input logic                reset_n,
  rom_dl_sequencer_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          wr_q, act_q, draining;
  logic          push, pop, act_rise, act_fall;
  logic          full, empty;
  logic [CW-1:0] count;
  dl_entry_t     wr_ent, head, hold;
  state_t        state;
  logic [TW-1:0] tmo_cnt;
  region_t       rgn;

  assign push     = bus.dl_wr & ~wr_q & bus.dl_active;
  assign pop      = (state == IDLE) & ~empty;
  assign act_rise = bus.dl_active & ~act_q;
  assign act_fall = ~bus.dl_active & act_q;
  assign wr_ent   = '{addr: bus.dl_addr, data: bus.dl_data};
  assign rgn      = decode_region(hold.addr, SND_LO, SP_BASE, PROM_BASE);

  assign bus.dl_wait = (count >= CW'(FIFO_DEPTH - 1)) | ((state != IDLE) & (count != '0));

  dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_ent),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q           <= 1'b0;
      act_q          <= 1'b0;
      draining       <= 1'b0;
      bus.rom_loaded <= 1'b0;
      bus.err_ovf    <= 1'b0;
    end else begin
      wr_q  <= bus.dl_wr;
      act_q <= bus.dl_active;
      if (act_rise) begin
        bus.rom_loaded <= 1'b0;
        bus.err_ovf    <= 1'b0;
        draining       <= 1'b0;
      end else begin
        if (push & full & ~pop) bus.err_ovf <= 1'b1;
        // Loaded only once everything queued before the fall has gone out.
        if (act_fall) draining <= 1'b1;
        else if (draining & empty & (state == IDLE)) begin
          bus.rom_loaded <= 1'b1;
          draining       <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hold          <= '0;
      tmo_cnt       <= '0;
      bus.p1_req    <= 1'b0;
      bus.p1_a      <= '0;
      bus.p1_ds     <= '0;
      bus.p1_d      <= '0;
      bus.p2_req    <= 1'b0;
      bus.p2_a      <= '0;
      bus.p2_ds     <= '0;
      bus.p2_d      <= '0;
      bus.snd_we    <= 1'b0;
      bus.snd_addr  <= '0;
      bus.snd_data  <= '0;
      bus.prom_we   <= 1'b0;
      bus.prom_addr <= '0;
      bus.prom_data <= '0;
      bus.err_tmo   <= 1'b0;
    end else begin
      bus.snd_we  <= 1'b0;
      bus.prom_we <= 1'b0;
      if (act_rise) bus.err_tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            hold  <= head;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.p1_req <= ~bus.p1_req;
          bus.p1_a   <= hold.addr[23:1];
          bus.p1_ds  <= {hold.addr[0], ~hold.addr[0]};
          bus.p1_d   <= {2{hold.data}};
          if (rgn == R_SPR) begin
            bus.p2_req <= ~bus.p2_req;
            bus.p2_a   <= 23'((hold.addr - SP_BASE) >> 1);
            bus.p2_ds  <= {hold.addr[0], ~hold.addr[0]};
            bus.p2_d   <= {2{hold.data}};
          end
          if (rgn == R_SND) begin
            bus.snd_we   <= 1'b1;
            bus.snd_addr <= hold.addr[15:0];
            bus.snd_data <= hold.data;
          end
          if (rgn == R_PROM) begin
            bus.prom_we   <= 1'b1;
            bus.prom_addr <= 12'(hold.addr - PROM_BASE);
            bus.prom_data <= hold.data;
          end
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if ((bus.p1_ack == bus.p1_req) && (bus.p2_ack == bus.p2_req)) begin
            state <= IDLE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Give up on this byte; it is not retried.
            bus.err_tmo <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Self-checking bench: table vectors, multi-cycle corner sequences and random traffic vs a queue model.
module tb_rom_dl_sequencer;

  localparam logic [24:0] T_SND  = 25'h20000;
  localparam logic [24:0] T_SP   = 25'h30000;
  localparam logic [24:0] T_PROM = 25'hA0000;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  rom_dl_sequencer_if bus ();
  rom_dl_sequencer dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } ent_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [22:0] p1_a;
    logic [1:0]  ds;
    logic        p2;
    logic        snd;
    logic        prom;
    logic [22:0] sub;
  } vec_t;

  int   nchk = 0, nerr = 0;
  int   cyc = 0, strobe_cyc = 0, issue_cyc = 0, issue_cnt = 0;
  ent_t exp_q[$];
  vec_t vt[8];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit in_snd(input logic [24:0] a);
    return (a >= T_SND) && (a < T_SP);
  endfunction
  function automatic bit in_spr(input logic [24:0] a);
    return (a >= T_SP) && (a < T_PROM);
  endfunction
  function automatic bit in_prom(input logic [24:0] a);
    return a >= T_PROM;
  endfunction

  // Acks follow reqs after a programmable delay unless frozen.
  logic hold1 = 1'b0, hold2 = 1'b0;
  int   dly1 = 1, dly2 = 1, c1 = 0, c2 = 0;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.p1_ack <= 1'b0; bus.p2_ack <= 1'b0; c1 <= 0; c2 <= 0;
    end else begin
      if (!hold1 && (bus.p1_ack != bus.p1_req)) begin
        if (c1 >= dly1) begin bus.p1_ack <= bus.p1_req; c1 <= 0; end
        else c1 <= c1 + 1;
      end
      if (!hold2 && (bus.p2_ack != bus.p2_req)) begin
        if (c2 >= dly2) begin bus.p2_ack <= bus.p2_req; c2 <= 0; end
        else c2 <= c2 + 1;
      end
    end
  end

  // Monitor: every p1 toggle must match the oldest accepted byte.
  logic        p1_prev = 1'b0, p2_prev = 1'b0, m_t1, m_t2;
  ent_t        m_e;
  logic [24:0] m_a;
  logic [22:0] s_p1_a, s_p2_a;
  logic [1:0]  s_p1_ds;
  logic        s_p2, s_snd, s_prom;
  logic [15:0] s_snd_addr;
  logic [11:0] s_prom_addr;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      p1_prev = 1'b0; p2_prev = 1'b0;
    end else begin
      m_t1 = bus.p1_req ^ p1_prev;
      m_t2 = bus.p2_req ^ p2_prev;
      p1_prev = bus.p1_req;
      p2_prev = bus.p2_req;
      if (m_t1) begin
        s_p1_a = bus.p1_a; s_p1_ds = bus.p1_ds; s_p2 = m_t2; s_p2_a = bus.p2_a;
        s_snd = bus.snd_we; s_snd_addr = bus.snd_addr;
        s_prom = bus.prom_we; s_prom_addr = bus.prom_addr;
        issue_cyc = cyc;
        issue_cnt++;
        if (exp_q.size() == 0) chk("mon_unexpected_issue", 32'd1, 32'd0);
        else begin
          m_e = exp_q.pop_front();
          m_a = m_e.addr;
          chk("mon_p1_a", 32'(bus.p1_a), 32'(m_a[23:1]));
          chk("mon_p1_ds", 32'(bus.p1_ds), 32'({m_a[0], ~m_a[0]}));
          chk("mon_p1_d", 32'(bus.p1_d), 32'({m_e.data, m_e.data}));
          chk("mon_p2_toggle", 32'(m_t2), 32'(in_spr(m_a)));
          chk("mon_snd_we", 32'(bus.snd_we), 32'(in_snd(m_a)));
          chk("mon_prom_we", 32'(bus.prom_we), 32'(in_prom(m_a)));
          if (in_spr(m_a)) begin
            chk("mon_p2_a", 32'(bus.p2_a), 32'((m_a - T_SP) >> 1));
            chk("mon_p2_ds", 32'(bus.p2_ds), 32'({m_a[0], ~m_a[0]}));
            chk("mon_p2_d", 32'(bus.p2_d), 32'({m_e.data, m_e.data}));
          end
          if (in_snd(m_a)) begin
            chk("mon_snd_addr", 32'(bus.snd_addr), 32'(m_a[15:0]));
            chk("mon_snd_data", 32'(bus.snd_data), 32'(m_e.data));
          end
          if (in_prom(m_a)) begin
            chk("mon_prom_addr", 32'(bus.prom_addr), 32'(m_a - T_PROM) & 32'hFFF);
            chk("mon_prom_data", 32'(bus.prom_data), 32'(m_e.data));
          end
        end
      end else if (m_t2 | bus.snd_we | bus.prom_we) begin
        chk("mon_stray_activity", 32'({m_t2, bus.snd_we, bus.prom_we}), 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honor, input bit acc);
    int n;
    n = 0;
    if (honor) begin
      while (bus.dl_wait && n < 3000) begin step(); n++; end
      if (n >= 3000) chk("send_dl_wait_bound", 32'd1, 32'd0);
    end
    bus.dl_addr = a;
    bus.dl_data = d;
    bus.dl_wr   = 1'b1;
    if (acc) exp_q.push_back('{addr: a, data: d});
    step();
    strobe_cyc = cyc;
    bus.dl_wr = 1'b0;
    step();
  endtask

  task automatic wait_issue(input int prev, input string nm);
    int n;
    n = 0;
    while (issue_cnt == prev && n < 200) begin step(); n++; end
    if (issue_cnt == prev) chk({nm, "_issue_bound"}, 32'd0, 32'd1);
  endtask

  task automatic settle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.p1_ack != bus.p1_req || bus.p2_ack != bus.p2_req ||
            bus.dl_wait) && n < 3000) begin
      step(); n++;
    end
    if (n >= 3000) chk({nm, "_settle_bound"}, 32'd1, 32'd0);
    repeat (3) step();
  endtask

  task automatic wait_loaded(input string nm);
    int n;
    n = 0;
    while (!bus.rom_loaded && n < 200) begin step(); n++; end
    chk(nm, 32'(bus.rom_loaded), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int          prev, n;
    logic [24:0] a;
    logic [7:0]  d;

    vt[0] = '{25'h00010, 8'hA5, 23'h00008, 2'b01, 1'b0, 1'b0, 1'b0, 23'h0};
    vt[1] = '{25'h20003, 8'h3C, 23'h10001, 2'b10, 1'b0, 1'b1, 1'b0, 23'h3};
    vt[2] = '{25'h30001, 8'h77, 23'h18000, 2'b10, 1'b1, 1'b0, 1'b0, 23'h0};
    vt[3] = '{25'hA0005, 8'h5A, 23'h50002, 2'b10, 1'b0, 1'b0, 1'b1, 23'h5};
    vt[4] = '{25'h1FFFF, 8'h01, 23'h0FFFF, 2'b10, 1'b0, 1'b0, 1'b0, 23'h0};
    vt[5] = '{25'h2FFFF, 8'h02, 23'h17FFF, 2'b10, 1'b0, 1'b1, 1'b0, 23'hFFFF};
    vt[6] = '{25'h30000, 8'h03, 23'h18000, 2'b01, 1'b1, 1'b0, 1'b0, 23'h0};
    vt[7] = '{25'h9FFFF, 8'h04, 23'h4FFFF, 2'b10, 1'b1, 1'b0, 1'b0, 23'h37FFF};

    bus.dl_active = 1'b0; bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
    repeat (3) step();
    chk("rst_outputs", 32'({bus.dl_wait, bus.p1_req, bus.p2_req, bus.snd_we, bus.prom_we,
                            bus.rom_loaded, bus.err_ovf, bus.err_tmo}), 32'd0);
    chk("rst_p1_a", 32'(bus.p1_a), 32'd0);
    reset_n = 1'b1;
    step();
    bus.dl_active = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      prev = issue_cnt;
      send_byte(vt[i].addr, vt[i].data, 1'b1, 1'b1);
      wait_issue(prev, "vec");
      if (i == 0) chk("vec_latency", 32'(issue_cyc - strobe_cyc), 32'd2);
      chk("vec_p1_a", 32'(s_p1_a), 32'(vt[i].p1_a));
      chk("vec_p1_ds", 32'(s_p1_ds), 32'(vt[i].ds));
      chk("vec_p2", 32'(s_p2), 32'(vt[i].p2));
      chk("vec_snd", 32'(s_snd), 32'(vt[i].snd));
      chk("vec_prom", 32'(s_prom), 32'(vt[i].prom));
      if (vt[i].p2)   chk("vec_p2_a", 32'(s_p2_a), 32'(vt[i].sub));
      if (vt[i].snd)  chk("vec_snd_addr", 32'(s_snd_addr), 32'(vt[i].sub));
      if (vt[i].prom) chk("vec_prom_addr", 32'(s_prom_addr), 32'(vt[i].sub));
      settle("vec");
    end

    // Sprite byte: next byte must wait for the slow port2 ack.
    dly2 = 10;
    prev = issue_cnt;
    send_byte(25'h30001, 8'h77, 1'b1, 1'b1);
    send_byte(25'h00020, 8'h11, 1'b0, 1'b1);
    wait_issue(prev, "hold");
    repeat (5) step();
    chk("hold_p1_acked", 32'(bus.p1_ack == bus.p1_req), 32'd1);
    chk("hold_no_second_issue", 32'(issue_cnt), 32'(prev + 1));
    chk("hold_dl_wait", 32'(bus.dl_wait), 32'd1);
    wait_issue(prev + 1, "hold2");
    chk("hold_second_after_p2_ack", 32'(bus.p2_ack), 32'(bus.p2_req));
    settle("hold");
    dly2 = 1;

    // Acks frozen for 20 cycles while an HPS that honours dl_wait sends 6 bytes.
    hold1 = 1'b1; hold2 = 1'b1;
    fork
      begin
        repeat (19) step();
        chk("flood_dl_wait_high", 32'(bus.dl_wait), 32'd1);
        step();
        hold1 = 1'b0; hold2 = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++)
          send_byte((i % 2 == 0) ? 25'(25'h00100 + 2 * i) : 25'(25'h30100 + i), 8'(8'h60 + i), 1'b1, 1'b1);
      end
    join
    settle("flood");
    chk("flood_all_issued", 32'(exp_q.size()), 32'd0);
    chk("flood_no_ovf", 32'(bus.err_ovf), 32'd0);

    // Ignoring dl_wait: one in flight plus four buffered, the sixth is dropped.
    hold1 = 1'b1;
    for (int i = 0; i < 6; i++)
      send_byte(25'(25'h00200 + i), 8'(8'hC0 + i), 1'b0, i < 5);
    chk("ovf_flag", 32'(bus.err_ovf), 32'd1);
    chk("ovf_dl_wait", 32'(bus.dl_wait), 32'd1);
    hold1 = 1'b0;
    settle("ovf");
    chk("ovf_five_issued", 32'(exp_q.size()), 32'd0);
    bus.dl_active = 1'b0;
    wait_loaded("ovf_rom_loaded");
    chk("ovf_sticky", 32'(bus.err_ovf), 32'd1);

    // Strobes while inactive are ignored.
    prev = issue_cnt;
    send_byte(25'h00300, 8'hEE, 1'b0, 1'b0);
    repeat (10) step();
    chk("inactive_ignored", 32'(issue_cnt), 32'(prev));
    bus.dl_active = 1'b1;
    repeat (2) step();
    chk("rise_clears", 32'({bus.err_ovf, bus.rom_loaded}), 32'd0);

    // Stuck port1 ack: timeout after exactly TIMEOUT cycles.
    hold1 = 1'b1;
    prev = issue_cnt;
    send_byte(25'h00040, 8'h42, 1'b1, 1'b1);
    wait_issue(prev, "tmo");
    n = 0;
    while (!bus.err_tmo && n < 1100) begin step(); n++; end
    chk("tmo_flag", 32'(bus.err_tmo), 32'd1);
    chk("tmo_latency", 32'(cyc - issue_cyc), 32'd1023);
    step();
    chk("tmo_back_idle", 32'(bus.dl_wait), 32'd0);
    bus.dl_active = 1'b0;
    wait_loaded("tmo_rom_loaded");
    hold1 = 1'b0;
    repeat (4) step();
    bus.dl_active = 1'b1;
    repeat (2) step();
    chk("tmo_cleared", 32'({bus.err_tmo, bus.rom_loaded}), 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 60; i++) begin
      dly1 = $urandom_range(0, 3);
      dly2 = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       a = 25'($urandom_range(0, 32'h1FFFF));
        1:       a = 25'($urandom_range(32'h20000, 32'h2FFFF));
        2:       a = 25'($urandom_range(32'h30000, 32'h9FFFF));
        default: a = 25'($urandom_range(32'hA0000, 32'hA0FFF));
      endcase
      d = 8'($urandom);
      send_byte(a, d, 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end
    settle("rand");
    chk("rand_all_issued", 32'(exp_q.size()), 32'd0);
    chk("rand_no_errors", 32'({bus.err_ovf, bus.err_tmo}), 32'd0);

    // Reset in the middle of a transfer.
    hold1 = 1'b1;
    prev = issue_cnt;
    send_byte(25'h00500, 8'h99, 1'b1, 1'b1);
    wait_issue(prev, "rst_mid");
    reset_n = 1'b0;
    step();
    chk("rst_mid_state", 32'({bus.p1_req, bus.dl_wait, bus.err_tmo, bus.rom_loaded}), 32'd0);
    exp_q.delete();
    hold1 = 1'b0;
    reset_n = 1'b1;
    repeat (2) step();
    prev = issue_cnt;
    send_byte(25'h20010, 8'h5C, 1'b1, 1'b1);
    wait_issue(prev, "rst_recover");
    settle("rst_recover");
    chk("rst_recover_done", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
